// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for the sequential multiplier.
// The master drives the request side and the slave is the multiplier.
interface seq_multiplier_if #(
  parameter int N = 24
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] R_lo;
  logic [N-1:0] R_hi;
  logic         Z_flag;
  logic         V_flag;

  modport master (
    output start, A, B,
    input  busy, done, R_lo, R_hi, Z_flag, V_flag
  );

  modport slave (
    input  start, A, B,
    output busy, done, R_lo, R_hi, Z_flag, V_flag
  );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-and-add unsigned multiplier: one multiplier bit per clock,
// N+1 edges from accepted start to the done pulse.
//
// state  | meaning
// IDLE   | waiting for start; operands are latched on the accepting edge
// RUN    | one add/shift per edge, exactly N edges
// DONE   | result registers valid, done high for this single cycle
module seq_multiplier #(
  parameter int N = 24
) (
  input logic          clk,
  input logic          rst,
  seq_multiplier_if.slave bus
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [N-1:0]  r_m;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_p;
  logic [CW-1:0] r_cnt;

  logic [N-1:0]  r_r_lo;
  logic [N-1:0]  r_r_hi;
  logic          r_z;
  logic          r_v;

  logic [N:0]    w_sum;
  logic [N-1:0]  w_p_next;
  logic [N-1:0]  w_q_next;
  logic          w_last;

  // Adder plus one-bit right shift of {carry, P, Q}. The carry-out lands
  // directly in P's MSB on the same edge, so no carry flop outlives an
  // iteration and "clearing carry" is implicit in the shift.
  always_comb begin
    w_sum    = {1'b0, r_p} + (r_q[0] ? {1'b0, r_m} : {(N+1){1'b0}});
    w_p_next = w_sum[N:1];
    w_q_next = {w_sum[0], r_q[N-1:1]};
    w_last   = (r_cnt == CW'(N - 1));
  end

  // Sequencer and datapath registers; start is only looked at in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_q     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_m     <= bus.A;
            r_q     <= bus.B;
            r_p     <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Result registers load only on the edge entering DONE, so they hold
  // the previous product through the whole next operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r_lo <= '0;
      r_r_hi <= '0;
      r_z    <= 1'b0;
      r_v    <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_r_lo <= w_q_next;
      r_r_hi <= w_p_next;
      r_z    <= ~(|w_p_next) & ~(|w_q_next);
      r_v    <= |w_p_next;
    end
  end

  assign bus.busy   = (r_state == S_RUN) || (r_state == S_DONE);
  assign bus.done   = (r_state == S_DONE);
  assign bus.R_lo   = r_r_lo;
  assign bus.R_hi   = r_r_hi;
  assign bus.Z_flag = r_z;
  assign bus.V_flag = r_v;

endmodule
